// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-RAM initiator: RAM command bus,
// RV32I load/store funct3 codes, FSM states and access-size helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; 0 marks an encoding that is not a legal load/store.
  function automatic logic [2:0] op_size(input logic is_load, input logic [2:0] funct3);
    case (funct3)
      F3_B:    op_size = 3'd1;
      F3_H:    op_size = 3'd2;
      F3_W:    op_size = 3'd4;
      F3_BU:   op_size = is_load ? 3'd1 : 3'd0;
      F3_HU:   op_size = is_load ? 3'd2 : 3'd0;
      default: op_size = 3'd0;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] lane, input logic [2:0] size);
    crosses_word = ({2'b00, lane} + {1'b0, size}) > 4'd4;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lsu_lane_align.sv
// Byte-lane steering between a {hi,lo} word pair and the core: load extract
// with sign/zero extension, and store merge of rs2 into the captured words.
module lsu_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [1:0]        lane_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [DATA_W-1:0] st_lo_o,
  output logic [DATA_W-1:0] st_hi_o
);

  logic [2*DATA_W-1:0] pair;
  logic [2*DATA_W-1:0] data_sh;
  logic [2*DATA_W-1:0] mask_sh;
  logic [2*DATA_W-1:0] merged;
  logic [DATA_W-1:0]   view;
  logic [DATA_W-1:0]   mask;
  logic [5:0]          shamt;

  assign pair  = {hi_i, lo_i};
  assign shamt = {1'b0, lane_i, 3'b000};
  assign view  = pair[shamt +: DATA_W];

  always_comb begin
    ld_data_o = '0;
    case (funct3_i)
      F3_B:    ld_data_o = {{(DATA_W-8){view[7]}}, view[7:0]};
      F3_H:    ld_data_o = {{(DATA_W-16){view[15]}}, view[15:0]};
      F3_W:    ld_data_o = view;
      F3_BU:   ld_data_o = {{(DATA_W-8){1'b0}}, view[7:0]};
      F3_HU:   ld_data_o = {{(DATA_W-16){1'b0}}, view[15:0]};
      default: ld_data_o = '0;
    endcase
  end

  // Store sizes share funct3[1:0] with the load sizes.
  always_comb begin
    mask = '0;
    case (funct3_i[1:0])
      2'b00:   mask[7:0]  = '1;
      2'b01:   mask[15:0] = '1;
      2'b10:   mask       = '1;
      default: mask       = '0;
    endcase
  end

  assign data_sh = {{DATA_W{1'b0}}, wdata_i} << shamt;
  assign mask_sh = {{DATA_W{1'b0}}, mask} << shamt;
  assign merged  = (pair & ~mask_sh) | (data_sh & mask_sh);
  assign st_lo_o = merged[DATA_W-1:0];
  assign st_hi_o = merged[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the word-granular data RAM: turns sub-word and
// word-crossing loads/stores into word read-modify-write sequences.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              op_valid_i,
  input  logic              op_load_i,
  input  logic [2:0]        op_funct3_i,
  input  logic [ADDR_W-1:0] op_addr_i,
  input  logic [DATA_W-1:0] op_wdata_i,
  output logic              stall_o,
  output logic              ld_valid_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              misalign_err_o,
  output logic [1:0]        mem_ctrl_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i
);

  state_e              state_q, state_d;
  logic                load_q, load_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;

  mem_cmd_e            cmd;
  logic [2:0]          in_size;
  logic                in_cross;
  logic                q_cross;
  logic [ADDR_W-3:0]   word_lo, word_hi;
  logic [DATA_W-1:0]   lo_view, hi_view;
  logic [DATA_W-1:0]   ld_ext, st_lo, st_hi;

  assign in_size  = op_size(op_load_i, op_funct3_i);
  assign in_cross = crosses_word(op_addr_i[1:0], in_size);
  assign q_cross  = crosses_word(addr_q[1:0], op_size(load_q, funct3_q));
  assign word_lo  = addr_q[ADDR_W-1:2];
  assign word_hi  = word_lo + 1'b1;

  // Read data is extracted in the cycle it arrives, so bypass the capture registers.
  assign lo_view = (state_q == ST_RD_LO) ? mem_rdata_i : lo_q;
  assign hi_view = (state_q == ST_RD_HI) ? mem_rdata_i : hi_q;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .lo_i      (lo_view),
    .hi_i      (hi_view),
    .lane_i    (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_ext),
    .st_lo_o   (st_lo),
    .st_hi_o   (st_hi)
  );

  always_comb begin
    state_d        = state_q;
    load_d         = load_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    lo_d           = lo_q;
    hi_d           = hi_q;
    err_d          = err_q;
    ld_data_d      = ld_data_q;
    cmd            = MEM_IDLE;
    stall_o        = 1'b0;
    ld_valid_o     = 1'b0;
    misalign_err_o = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid_i) begin
          stall_o  = 1'b1;
          load_d   = op_load_i;
          funct3_d = op_funct3_i;
          addr_d   = op_addr_i;
          wdata_d  = op_wdata_i;
          err_d    = 1'b0;
          if (in_size == 3'd0) begin
            state_d = ST_RESP;
            if (op_load_i) ld_data_d = '0;
          end else if (in_cross && !MISALIGN_EN) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (!op_load_i && in_size == 3'd4 && !in_cross) begin
            state_d = ST_WR_LO;
          end else begin
            state_d = ST_RD_LO;
          end
        end
      end
      ST_RD_LO: begin
        stall_o    = 1'b1;
        cmd        = MEM_READ;
        mem_addr_o = {2'b00, word_lo};
        if (mem_rvalid_i) begin
          lo_d = mem_rdata_i;
          if (q_cross) begin
            state_d = ST_RD_HI;
          end else if (!load_q) begin
            state_d = ST_WR_LO;
          end else begin
            state_d   = ST_RESP;
            ld_data_d = ld_ext;
          end
        end
      end
      ST_RD_HI: begin
        stall_o    = 1'b1;
        cmd        = MEM_READ;
        mem_addr_o = {2'b00, word_hi};
        if (mem_rvalid_i) begin
          hi_d = mem_rdata_i;
          if (!load_q) begin
            state_d = ST_WR_LO;
          end else begin
            state_d   = ST_RESP;
            ld_data_d = ld_ext;
          end
        end
      end
      ST_WR_LO: begin
        stall_o     = 1'b1;
        cmd         = MEM_WRITE;
        mem_addr_o  = {2'b00, word_lo};
        mem_wdata_o = st_lo;
        state_d     = q_cross ? ST_WR_HI : ST_RESP;
      end
      ST_WR_HI: begin
        stall_o     = 1'b1;
        cmd         = MEM_WRITE;
        mem_addr_o  = {2'b00, word_hi};
        mem_wdata_o = st_hi;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        ld_valid_o     = load_q && !err_q;
        misalign_err_o = err_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      load_q    <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign mem_ctrl_o = cmd;
  assign ld_data_o  = ld_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected RAM commands and load results
// are queued by the stimulus and popped by a negedge monitor.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        opValid, opLoad;
  logic [2:0]  opFunct3;
  logic [31:0] opAddr, opWdata;
  logic        stall, ldValid, misalignErr, memRvalid;
  logic [31:0] ldData, memAddr, memWdata, memRdata;
  logic [1:0]  memCtrl;

  logic        op2Valid, op2Load;
  logic [2:0]  op2Funct3;
  logic [31:0] op2Addr;
  logic        stall2, ldValid2, misalignErr2, mem2Rvalid;
  logic [31:0] ldData2, mem2Addr, mem2Wdata;
  logic [1:0]  mem2Ctrl;

  logic [31:0] ram [16];
  logic        pokeEn;
  logic [3:0]  pokeIdx;
  logic [31:0] pokeData;
  int          rdDelay;
  int          waitCnt;
  logic        monitorOn;

  cmd_t        expCmd[$];
  logic [31:0] expLoad[$];
  cmd_t        gotCmd;
  logic [31:0] gotLoad;
  int          checksTotal;
  int          checksPassed;
  int          stallCycles;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .op_valid_i(opValid), .op_load_i(opLoad), .op_funct3_i(opFunct3),
    .op_addr_i(opAddr), .op_wdata_i(opWdata),
    .stall_o(stall), .ld_valid_o(ldValid), .ld_data_o(ldData),
    .misalign_err_o(misalignErr), .mem_ctrl_o(memCtrl), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata), .mem_rvalid_i(memRvalid)
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dutNoSplit (
    .clk_i(clk), .rst_i(rst),
    .op_valid_i(op2Valid), .op_load_i(op2Load), .op_funct3_i(op2Funct3),
    .op_addr_i(op2Addr), .op_wdata_i(32'h0),
    .stall_o(stall2), .ld_valid_o(ldValid2), .ld_data_o(ldData2),
    .misalign_err_o(misalignErr2), .mem_ctrl_o(mem2Ctrl), .mem_addr_o(mem2Addr),
    .mem_wdata_o(mem2Wdata), .mem_rdata_i(32'h0), .mem_rvalid_i(mem2Rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with a programmable read latency measured in held Read cycles.
  assign memRvalid  = (memCtrl == MEM_READ) && (waitCnt >= rdDelay);
  assign memRdata   = ram[memAddr[3:0]];
  assign mem2Rvalid = (mem2Ctrl == MEM_READ);

  always @(posedge clk) begin
    if (pokeEn) ram[pokeIdx] <= pokeData;
    else if (memCtrl == MEM_WRITE) ram[memAddr[3:0]] <= memWdata;
    if (memCtrl == MEM_READ && !memRvalid) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] data);
    pokeIdx  = idx;
    pokeData = data;
    pokeEn   = 1'b1;
    @(posedge clk);
    #1 pokeEn = 1'b0;
  endtask

  task automatic pushCmd(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.ctrl  = ctrl;
    c.addr  = addr;
    c.wdata = wdata;
    expCmd.push_back(c);
  endtask

  // Presents one op and holds it until the stall drops; reports stalled cycles.
  task automatic applyStimulus(input logic load, input logic [2:0] funct3, input logic [31:0] addr,
                               input logic [31:0] wdata, output int stalls);
    int cnt;
    opLoad   = load;
    opFunct3 = funct3;
    opAddr   = addr;
    opWdata  = wdata;
    opValid  = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (stall && cnt < 50);
    if (stall) checkOutput("stallTimeout", {63'b0, stall}, 64'h0);
    stalls = cnt - 1;
    @(posedge clk);
    #1 opValid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      if (memCtrl == MEM_WRITE || (memCtrl == MEM_READ && memRvalid)) begin
        if (expCmd.size() == 0) begin
          checkOutput("cmdUnexpected", {30'b0, memCtrl, memAddr}, 64'h0);
        end else begin
          gotCmd = expCmd.pop_front();
          checkOutput("cmdCtrl", {62'b0, memCtrl}, {62'b0, gotCmd.ctrl});
          checkOutput("cmdAddr", {32'b0, memAddr}, {32'b0, gotCmd.addr});
          checkOutput("cmdWdata", {32'b0, memWdata}, {32'b0, gotCmd.wdata});
        end
      end
      if (memCtrl == MEM_IDLE) checkOutput("idleBus", {memAddr, memWdata}, 64'h0);
      if (ldValid) begin
        if (expLoad.size() == 0) begin
          checkOutput("loadUnexpected", {32'b0, ldData}, 64'h0);
        end else begin
          gotLoad = expLoad.pop_front();
          checkOutput("ldData", {32'b0, ldData}, {32'b0, gotLoad});
        end
      end
      if (misalignErr) checkOutput("misalignErrSplitMode", {63'b0, misalignErr}, 64'h0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    checksTotal = 0;
    checksPassed = 0;
    monitorOn = 1'b0;
    rst = 1'b1;
    pokeEn = 1'b0; pokeIdx = '0; pokeData = '0;
    rdDelay = 0;
    opValid = 1'b0; opLoad = 1'b0; opFunct3 = '0; opAddr = '0; opWdata = '0;
    op2Valid = 1'b0; op2Load = 1'b0; op2Funct3 = '0; op2Addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstStall", {63'b0, stall}, 64'h0);
    checkOutput("rstLdValid", {63'b0, ldValid}, 64'h0);
    checkOutput("rstLdData", {32'b0, ldData}, 64'h0);
    checkOutput("rstMisalign", {63'b0, misalignErr}, 64'h0);
    checkOutput("rstCtrl", {62'b0, memCtrl}, 64'h0);
    checkOutput("rstBus", {memAddr, memWdata}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    monitorOn = 1'b1;

    poke(4'd4, 32'hDEADBEEF);
    pushCmd(MEM_READ, 32'h4, 32'h0);
    expLoad.push_back(32'hDEADBEEF);
    applyStimulus(1'b1, F3_W, 32'h10, 32'h0, stallCycles);
    checkOutput("lwLatency", stallCycles, 64'd2);

    poke(4'd4, 32'h80FFFFFF);
    pushCmd(MEM_READ, 32'h4, 32'h0);
    expLoad.push_back(32'hFFFFFF80);
    applyStimulus(1'b1, F3_B, 32'h13, 32'h0, stallCycles);
    pushCmd(MEM_READ, 32'h4, 32'h0);
    expLoad.push_back(32'h00000080);
    applyStimulus(1'b1, F3_BU, 32'h13, 32'h0, stallCycles);

    poke(4'd8, 32'h11223344);
    pushCmd(MEM_READ, 32'h8, 32'h0);
    pushCmd(MEM_WRITE, 32'h8, 32'h1122AB44);
    applyStimulus(1'b0, F3_B, 32'h21, 32'h000000AB, stallCycles);
    checkOutput("sbStalls", stallCycles, 64'd3);

    poke(4'd1, 32'h11223344);
    poke(4'd2, 32'h55667788);
    pushCmd(MEM_READ, 32'h1, 32'h0);
    pushCmd(MEM_READ, 32'h2, 32'h0);
    pushCmd(MEM_WRITE, 32'h1, 32'hCCDD3344);
    pushCmd(MEM_WRITE, 32'h2, 32'h5566AABB);
    applyStimulus(1'b0, F3_W, 32'h06, 32'hAABBCCDD, stallCycles);
    checkOutput("swSplitStalls", stallCycles, 64'd5);

    pushCmd(MEM_READ, 32'h1, 32'h0);
    pushCmd(MEM_READ, 32'h2, 32'h0);
    expLoad.push_back(32'hFFFFBBCC);
    applyStimulus(1'b1, F3_H, 32'h07, 32'h0, stallCycles);
    checkOutput("lhSplitStalls", stallCycles, 64'd3);

    pushCmd(MEM_WRITE, 32'hC, 32'h01020304);
    applyStimulus(1'b0, F3_W, 32'h30, 32'h01020304, stallCycles);
    checkOutput("swAlignedStalls", stallCycles, 64'd2);

    pushCmd(MEM_READ, 32'h8, 32'h0);
    expLoad.push_back(32'h00001122);
    applyStimulus(1'b1, F3_HU, 32'h22, 32'h0, stallCycles);

    poke(4'd15, 32'h89ABCDEF);
    poke(4'd0, 32'h76543210);
    pushCmd(MEM_READ, 32'h3FFFFFFF, 32'h0);
    pushCmd(MEM_READ, 32'h0, 32'h0);
    expLoad.push_back(32'h321089AB);
    applyStimulus(1'b1, F3_W, 32'hFFFFFFFE, 32'h0, stallCycles);

    rdDelay = 3;
    pushCmd(MEM_READ, 32'h4, 32'h0);
    expLoad.push_back(32'h80FFFFFF);
    applyStimulus(1'b1, F3_W, 32'h10, 32'h0, stallCycles);
    checkOutput("slowReadStalls", stallCycles, 64'd5);
    rdDelay = 0;

    expLoad.push_back(32'h0);
    applyStimulus(1'b1, 3'b011, 32'h10, 32'h0, stallCycles);
    checkOutput("unknownF3Stalls", stallCycles, 64'd1);

    op2Load = 1'b1; op2Funct3 = F3_H; op2Addr = 32'h3; op2Valid = 1'b1;
    @(negedge clk);
    checkOutput("noSplitAcceptStall", {63'b0, stall2}, 64'h1);
    checkOutput("noSplitAcceptCtrl", {62'b0, mem2Ctrl}, 64'h0);
    @(negedge clk);
    checkOutput("noSplitErr", {63'b0, misalignErr2}, 64'h1);
    checkOutput("noSplitRespStall", {63'b0, stall2}, 64'h0);
    checkOutput("noSplitRespCtrl", {62'b0, mem2Ctrl}, 64'h0);
    checkOutput("noSplitLdValid", {63'b0, ldValid2}, 64'h0);
    @(posedge clk);
    #1 op2Valid = 1'b0;
    @(negedge clk);
    checkOutput("noSplitErrPulse", {63'b0, misalignErr2}, 64'h0);
    @(posedge clk);
    #1;

    rdDelay = 10;
    pushCmd(MEM_READ, 32'h1, 32'h0);
    opLoad = 1'b1; opFunct3 = F3_H; opAddr = 32'h07; opWdata = 32'h0; opValid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(memCtrl == MEM_READ && memAddr == 32'h2) && cnt < 60);
    checkOutput("reachRdHiAddr", {32'b0, memAddr}, 64'h2);
    checkOutput("reachRdHiStall", {63'b0, stall}, 64'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    opValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstStall", {63'b0, stall}, 64'h0);
    checkOutput("midRstCtrl", {62'b0, memCtrl}, 64'h0);
    checkOutput("midRstLdValid", {63'b0, ldValid}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    rdDelay = 0;

    pushCmd(MEM_READ, 32'h4, 32'h0);
    expLoad.push_back(32'h80FFFFFF);
    applyStimulus(1'b1, F3_W, 32'h10, 32'h0, stallCycles);
    checkOutput("postRstLatency", stallCycles, 64'd2);

    repeat (2) @(posedge clk);
    checkOutput("cmdLeftover", expCmd.size(), 64'd0);
    checkOutput("loadLeftover", expLoad.size(), 64'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
